// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong ball sequencer and its tick generator.
package pong_pkg;

  typedef enum logic [2:0] {
    StInit,
    StDrawWait,
    StIdle,
    StEraseWait,
    StUpdate
  } seq_state_e;

  localparam int unsigned ScreenWDefault = 160;
  localparam int unsigned ScreenHDefault = 120;

  localparam logic [2:0] ColourWhite = 3'b111;
  localparam logic [2:0] ColourBlack = 3'b000;

endpackage

// File: rtl/ball_sequencer_if.sv
// Request/completion handshake between the ball sequencer and the square draw engine.
interface ball_sequencer_if;

  logic       draw_start;
  logic       draw_done;
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  logic [2:0] draw_colour;

  modport master (
    output draw_start,
    output draw_x,
    output draw_y,
    output draw_colour,
    input  draw_done
  );

  modport slave (
    input  draw_start,
    input  draw_x,
    input  draw_y,
    input  draw_colour,
    output draw_done
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running down-counter producing a one-cycle motion tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = (count_q == '0);

  always_comb begin
    count_d = count_q - 1'b1;
    if (tick) begin
      count_d = Reload;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= Reload;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ball_sequencer.sv
// Bouncing-ball controller: erases and redraws a square once per motion tick through
// an external draw engine, reflecting off the screen edges.
module ball_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE   = 5,
  parameter int unsigned SCREEN_W    = ScreenWDefault,
  parameter int unsigned SCREEN_H    = ScreenHDefault,
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned X0          = 20,
  parameter int unsigned Y0          = 10,
  parameter logic [2:0]  BALL_COLOUR = ColourWhite,
  parameter logic [2:0]  BG_COLOUR   = ColourBlack
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  ball_sequencer_if.master draw,
  output logic [7:0]       ball_x,
  output logic [6:0]       ball_y,
  output logic             bounce
);

  seq_state_e state_q, state_d;
  logic [7:0] ball_x_q, ball_x_d, out_x_q, out_x_d;
  logic [6:0] ball_y_q, ball_y_d, out_y_q, out_y_d;
  logic [2:0] colour_q, colour_d;
  logic       dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic       pending_q, pending_d;
  logic       start_q, start_d;
  logic       bounce_q, bounce_d;
  logic       tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Wall tests and stepping use one extra bit so the edge sum cannot wrap.
  logic [8:0] x_ext, x_next;
  logic [7:0] y_ext, y_next;
  logic       hit_x, hit_y, new_dx_neg, new_dy_neg;

  always_comb begin
    x_ext      = {1'b0, ball_x_q};
    y_ext      = {1'b0, ball_y_q};
    hit_x      = dx_neg_q ? (x_ext == 9'd0) : (x_ext + 9'(BALL_SIZE) == 9'(SCREEN_W));
    hit_y      = dy_neg_q ? (y_ext == 8'd0) : (y_ext + 8'(BALL_SIZE) == 8'(SCREEN_H));
    new_dx_neg = dx_neg_q ^ hit_x;
    new_dy_neg = dy_neg_q ^ hit_y;
    x_next     = new_dx_neg ? x_ext - 9'd1 : x_ext + 9'd1;
    y_next     = new_dy_neg ? y_ext - 8'd1 : y_ext + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    colour_d  = colour_q;
    start_d   = 1'b0;
    bounce_d  = 1'b0;
    // Any tick not consumed below is remembered; a second one is simply absorbed.
    pending_d = pending_q | tick;
    unique case (state_q)
      StInit: begin
        start_d  = 1'b1;
        out_x_d  = 8'(X0);
        out_y_d  = 7'(Y0);
        colour_d = BALL_COLOUR;
        state_d  = StDrawWait;
      end
      StDrawWait: begin
        if (draw.draw_done) state_d = StIdle;
      end
      StIdle: begin
        if ((tick || pending_q) && enable) begin
          start_d   = 1'b1;
          out_x_d   = ball_x_q;
          out_y_d   = ball_y_q;
          colour_d  = BG_COLOUR;
          pending_d = 1'b0;
          state_d   = StEraseWait;
        end
      end
      StEraseWait: begin
        if (draw.draw_done) state_d = StUpdate;
      end
      StUpdate: begin
        dx_neg_d = new_dx_neg;
        dy_neg_d = new_dy_neg;
        ball_x_d = 8'(x_next);
        ball_y_d = 7'(y_next);
        out_x_d  = 8'(x_next);
        out_y_d  = 7'(y_next);
        colour_d = BALL_COLOUR;
        start_d  = 1'b1;
        bounce_d = hit_x | hit_y;
        state_d  = StDrawWait;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StInit;
      ball_x_q  <= 8'(X0);
      ball_y_q  <= 7'(Y0);
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      bounce_q  <= 1'b0;
      out_x_q   <= 8'(X0);
      out_y_q   <= 7'(Y0);
      colour_q  <= BALL_COLOUR;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      bounce_q  <= bounce_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      colour_q  <= colour_d;
    end
  end

  assign draw.draw_start  = start_q;
  assign draw.draw_x      = out_x_q;
  assign draw.draw_y      = out_y_q;
  assign draw.draw_colour = colour_q;
  assign ball_x           = ball_x_q;
  assign ball_y           = ball_y_q;
  assign bounce           = bounce_q;

endmodule

// File: tb/tb_ball_sequencer.sv
// Directed bench for ball_sequencer on a 16x12 screen with a 2-pixel ball and a model
// draw engine whose latency can be stretched.
module tb_ball_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       spurious_done;
  logic       model_done;
  logic       busy;
  int         cnt;
  int         draw_delay = 3;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       bounce;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int bounce_count = 0;
  int overlap = 0;
  int unstable = 0;

  logic [17:0] prev_out;
  logic        prev_valid;

  logic [7:0] ex, nx;
  logic [6:0] ey, ny;
  logic [2:0] ec, nc;
  logic       nb;
  int         starts, s0;

  ball_sequencer_if dif ();

  ball_sequencer #(
    .BALL_SIZE  (2),
    .SCREEN_W   (16),
    .SCREEN_H   (12),
    .TICK_DIV   (4),
    .X0         (3),
    .Y0         (3),
    .BALL_COLOUR(3'b111),
    .BG_COLOUR  (3'b000)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .enable(enable),
    .draw  (dif),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .bounce(bounce)
  );

  always #5 clk = ~clk;

  assign dif.draw_done = model_done | spurious_done;

  // Draw engine model: done pulses draw_delay cycles after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      cnt        <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (dif.draw_start) begin
        busy <= 1'b1;
        cnt  <= draw_delay - 1;
      end else if (busy) begin
        if (cnt == 1) begin
          model_done <= 1'b1;
          busy       <= 1'b0;
          cnt        <= 0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (dif.draw_start) start_count <= start_count + 1;
    if (bounce) bounce_count <= bounce_count + 1;
    if (dif.draw_start && busy) overlap <= overlap + 1;
  end

  // Draw coordinates may only move in a cycle where draw_start is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= 1'b1;
      prev_out   <= {dif.draw_x, dif.draw_y, dif.draw_colour};
      if (prev_valid && !dif.draw_start &&
          ({dif.draw_x, dif.draw_y, dif.draw_colour} != prev_out)) begin
        unstable <= unstable + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_xyc(input string tag, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input int xe, input int ye, input int ce);
    check({tag, " x"}, 32'(x), 32'(xe));
    check({tag, " y"}, 32'(y), 32'(ye));
    check({tag, " colour"}, 32'(c), 32'(ce));
  endtask

  task automatic wait_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = dif.draw_start;
    end
    check({tag, " start seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = dif.draw_done;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
  endtask

  // One complete erase/draw step, then enable is left low so the FSM parks in idle.
  task automatic move(output logic [7:0] oex, output logic [6:0] oey, output logic [2:0] oec,
                      output logic [7:0] onx, output logic [6:0] ony, output logic [2:0] onc,
                      output logic onb, output int ostarts);
    int base;
    base   = start_count;
    enable = 1'b1;
    wait_start("erase");
    oex    = dif.draw_x;
    oey    = dif.draw_y;
    oec    = dif.draw_colour;
    enable = 1'b0;
    wait_start("draw");
    onx    = dif.draw_x;
    ony    = dif.draw_y;
    onc    = dif.draw_colour;
    onb    = bounce;
    wait_done("draw");
    ostarts = start_count - base;
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    spurious_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset draw_start", 32'(dif.draw_start), 32'd0);
    check("reset bounce", 32'(bounce), 32'd0);
    check("reset ball_x", 32'(ball_x), 32'd3);
    check("reset ball_y", 32'(ball_y), 32'd3);
    check_xyc("reset draw", dif.draw_x, dif.draw_y, dif.draw_colour, 3, 3, 7);

    // Init draw appears one cycle after release.
    rst_n = 1'b1;
    check("release start low", 32'(dif.draw_start), 32'd0);
    @(negedge clk);
    check("init start", 32'(dif.draw_start), 32'd1);
    check_xyc("init draw", dif.draw_x, dif.draw_y, dif.draw_colour, 3, 3, 7);
    @(negedge clk);
    check("init start one cycle", 32'(dif.draw_start), 32'd0);
    wait_done("init");
    repeat (12) @(negedge clk);
    check("init single start", 32'(start_count), 32'd1);

    move(ex, ey, ec, nx, ny, nc, nb, starts);
    check_xyc("m1 erase", ex, ey, ec, 3, 3, 0);
    check_xyc("m1 draw", nx, ny, nc, 4, 4, 7);
    check("m1 bounce", 32'(nb), 32'd0);
    check("m1 starts", 32'(starts), 32'd2);

    for (int m = 2; m <= 68; m++) begin
      move(ex, ey, ec, nx, ny, nc, nb, starts);
      if (m == 8) begin
        check_xyc("m8 erase", ex, ey, ec, 10, 10, 0);
        check_xyc("m8 bottom bounce", nx, ny, nc, 11, 9, 7);
        check("m8 bounce", 32'(nb), 32'd1);
      end
      if (m == 11) begin
        check_xyc("m11 draw", nx, ny, nc, 14, 6, 7);
        check("m11 bounce", 32'(nb), 32'd0);
      end
      if (m == 12) begin
        check_xyc("m12 erase", ex, ey, ec, 14, 6, 0);
        check_xyc("m12 right bounce", nx, ny, nc, 13, 5, 7);
        check("m12 bounce", 32'(nb), 32'd1);
      end
      if (m == 67) begin
        check_xyc("m67 corner", nx, ny, nc, 14, 10, 7);
        check("m67 bounce", 32'(nb), 32'd0);
      end
      if (m == 68) begin
        check_xyc("m68 erase", ex, ey, ec, 14, 10, 0);
        check_xyc("m68 corner bounce", nx, ny, nc, 13, 9, 7);
        check("m68 bounce", 32'(nb), 32'd1);
        check("m68 starts", 32'(starts), 32'd2);
      end
    end
    check("bounce pulses", 32'(bounce_count), 32'd11);

    // draw_done while idle must be ignored.
    repeat (3) @(negedge clk);
    s0 = start_count;
    spurious_done = 1'b1;
    @(negedge clk);
    spurious_done = 1'b0;
    repeat (8) @(negedge clk);
    check("idle done ignored starts", 32'(start_count - s0), 32'd0);
    check("idle done ball_x", 32'(ball_x), 32'd13);
    check("idle done ball_y", 32'(ball_y), 32'd9);
    move(ex, ey, ec, nx, ny, nc, nb, starts);
    check_xyc("m69 erase", ex, ey, ec, 13, 9, 0);
    check_xyc("m69 draw", nx, ny, nc, 12, 8, 7);

    // Disable during erase: the step completes, then motion freezes until re-enabled.
    enable = 1'b1;
    wait_start("m70 erase");
    check_xyc("m70 erase", dif.draw_x, dif.draw_y, dif.draw_colour, 12, 8, 0);
    enable = 1'b0;
    wait_start("m70 draw");
    check_xyc("m70 draw", dif.draw_x, dif.draw_y, dif.draw_colour, 11, 7, 7);
    wait_done("m70");
    s0 = start_count;
    repeat (20) @(negedge clk);
    check("frozen starts", 32'(start_count - s0), 32'd0);
    check("frozen ball_x", 32'(ball_x), 32'd11);
    check("frozen ball_y", 32'(ball_y), 32'd7);
    enable = 1'b1;
    @(negedge clk);
    check("resume on pending", 32'(dif.draw_start), 32'd1);
    check_xyc("m71 erase", dif.draw_x, dif.draw_y, dif.draw_colour, 11, 7, 0);
    enable = 1'b0;
    wait_start("m71 draw");
    check_xyc("m71 draw", dif.draw_x, dif.draw_y, dif.draw_colour, 10, 6, 7);
    wait_done("m71");

    // Slow engine: many ticks land while busy but only one move is owed.
    draw_delay = 10;
    move(ex, ey, ec, nx, ny, nc, nb, starts);
    check_xyc("m72 erase", ex, ey, ec, 10, 6, 0);
    check_xyc("m72 draw", nx, ny, nc, 9, 5, 7);
    check("m72 starts", 32'(starts), 32'd2);
    s0 = start_count;
    repeat (30) @(negedge clk);
    check("slow no backlog", 32'(start_count - s0), 32'd0);
    move(ex, ey, ec, nx, ny, nc, nb, starts);
    check_xyc("m73 draw", nx, ny, nc, 8, 4, 7);
    check("m73 starts", 32'(starts), 32'd2);
    draw_delay = 3;

    // Reset during a draw wait.
    enable = 1'b1;
    wait_start("m74 erase");
    enable = 1'b0;
    wait_start("m74 draw");
    check_xyc("m74 draw", dif.draw_x, dif.draw_y, dif.draw_colour, 7, 3, 7);
    #2 rst_n = 1'b0;
    #1;
    check("async reset start", 32'(dif.draw_start), 32'd0);
    check("async reset ball_x", 32'(ball_x), 32'd3);
    check("async reset ball_y", 32'(ball_y), 32'd3);
    check_xyc("async reset draw", dif.draw_x, dif.draw_y, dif.draw_colour, 3, 3, 7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("re-init start", 32'(dif.draw_start), 32'd1);
    check_xyc("re-init draw", dif.draw_x, dif.draw_y, dif.draw_colour, 3, 3, 7);
    wait_done("re-init");
    move(ex, ey, ec, nx, ny, nc, nb, starts);
    check_xyc("post reset erase", ex, ey, ec, 3, 3, 0);
    check_xyc("post reset draw", nx, ny, nc, 4, 4, 7);
    check("post reset bounce", 32'(nb), 32'd0);

    repeat (4) @(negedge clk);
    check("start while busy", 32'(overlap), 32'd0);
    check("coords unstable", 32'(unstable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
